// File: rtl/adrv9001_tx_unpack_pkg.sv
// Shared constants, state encoding and bit-order helpers for the ADRV9001 TX framer.
// The bit-reverse helper is the same one the receive pack/align path uses.
package adrv9001_tx_unpack_pkg;

   localparam int IQ_WIDTH     = 16;
   localparam int SERDES_RATIO = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_e;

   function automatic logic [SERDES_RATIO-1:0] bit_reverse8(input logic [SERDES_RATIO-1:0] b);
      logic [SERDES_RATIO-1:0] r;
      r = {SERDES_RATIO{1'b0}};
      for (int k = 0; k < SERDES_RATIO; k++) begin
         r[k] = b[SERDES_RATIO-1-k];
      end
      return r;
   endfunction

   // Serdes sends bit 0 first, so the MSB of the selected byte must land in bit 0.
   function automatic logic [SERDES_RATIO-1:0] lane_byte(input logic [IQ_WIDTH-1:0] w,
                                                         input logic upper);
      logic [SERDES_RATIO-1:0] r;
      if (upper) begin
         r = bit_reverse8(w[IQ_WIDTH-1:SERDES_RATIO]);
      end else begin
         r = bit_reverse8(w[SERDES_RATIO-1:0]);
      end
      return r;
   endfunction

endpackage

// File: rtl/adrv9001_tx_unpack.sv
// ADRV9001 LVDS TX framer: splits 32-bit {I,Q} samples into MSB-first byte pairs on the
// I, Q and strobe serdes lanes, one sample every two divided-clock cycles.
module adrv9001_tx_unpack
   import adrv9001_tx_unpack_pkg::*;
#(
   parameter logic [15:0] STROBE_PATTERN = 16'h8000,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic                      s_axis_aclk,
   input  logic                      s_axis_rstn,
   input  logic [2*IQ_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      tx_en,
   output logic [SERDES_RATIO-1:0]   i_data,
   output logic [SERDES_RATIO-1:0]   q_data,
   output logic [SERDES_RATIO-1:0]   strobe,
   output logic                      active,
   output logic [CNT_WIDTH-1:0]      underflow_cnt
);

   tx_state_e               state_r;
   logic                    phase_r;
   logic [2*IQ_WIDTH-1:0]   hold_r;
   logic                    hold_vld_r;
   logic [SERDES_RATIO-1:0] lo_i_r;
   logic [SERDES_RATIO-1:0] lo_q_r;
   logic [SERDES_RATIO-1:0] i_data_r;
   logic [SERDES_RATIO-1:0] q_data_r;
   logic [SERDES_RATIO-1:0] strobe_r;
   logic                    active_r;
   logic                    tready_r;
   logic [CNT_WIDTH-1:0]    cnt_r;

   tx_state_e               state_nxt_s;
   logic                    phase_nxt_s;
   logic                    hold_vld_nxt_s;
   logic                    tready_nxt_s;
   logic                    accept_s;
   logic                    consume_s;
   logic                    underflow_s;

   assign s_axis_tready = tready_r;
   assign i_data        = i_data_r;
   assign q_data        = q_data_r;
   assign strobe        = strobe_r;
   assign active        = active_r;
   assign underflow_cnt = cnt_r;

   // Next-state, hold occupancy and ready decode from the current registers.
   always_comb begin
      state_nxt_s = state_r;
      phase_nxt_s = phase_r;
      consume_s   = 1'b0;
      underflow_s = 1'b0;
      accept_s    = s_axis_tvalid & tready_r;
      case (state_r)
         ST_IDLE: begin
            phase_nxt_s = 1'b0;
            if (tx_en && hold_vld_r) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!phase_r) begin
               phase_nxt_s = 1'b1;
               if (hold_vld_r) begin
                  consume_s = 1'b1;
               end else begin
                  underflow_s = 1'b1;
               end
            end else begin
               // Exit only at a word boundary so a word is never truncated.
               phase_nxt_s = 1'b0;
               if (!tx_en) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            phase_nxt_s = 1'b0;
         end
      endcase
      hold_vld_nxt_s = accept_s | (hold_vld_r & ~consume_s);
      tready_nxt_s   = ~hold_vld_nxt_s | ((state_nxt_s == ST_RUN) & ~phase_nxt_s);
   end

   // Framing state, input buffer, lane bytes and underflow counter.
   always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
      if (!s_axis_rstn) begin
         state_r    <= ST_IDLE;
         phase_r    <= 1'b0;
         hold_r     <= {(2*IQ_WIDTH){1'b0}};
         hold_vld_r <= 1'b0;
         lo_i_r     <= {SERDES_RATIO{1'b0}};
         lo_q_r     <= {SERDES_RATIO{1'b0}};
         i_data_r   <= {SERDES_RATIO{1'b0}};
         q_data_r   <= {SERDES_RATIO{1'b0}};
         strobe_r   <= {SERDES_RATIO{1'b0}};
         active_r   <= 1'b0;
         tready_r   <= 1'b0;
         cnt_r      <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         phase_r    <= phase_nxt_s;
         hold_vld_r <= hold_vld_nxt_s;
         tready_r   <= tready_nxt_s;
         active_r   <= (state_nxt_s == ST_RUN);
         if (accept_s) begin
            hold_r <= s_axis_tdata;
         end
         case (state_r)
            ST_IDLE: begin
               i_data_r <= {SERDES_RATIO{1'b0}};
               q_data_r <= {SERDES_RATIO{1'b0}};
               strobe_r <= {SERDES_RATIO{1'b0}};
            end
            ST_RUN: begin
               if (!phase_r) begin
                  strobe_r <= lane_byte(STROBE_PATTERN, 1'b1);
                  if (consume_s) begin
                     i_data_r <= lane_byte(hold_r[2*IQ_WIDTH-1:IQ_WIDTH], 1'b1);
                     q_data_r <= lane_byte(hold_r[IQ_WIDTH-1:0], 1'b1);
                     lo_i_r   <= lane_byte(hold_r[2*IQ_WIDTH-1:IQ_WIDTH], 1'b0);
                     lo_q_r   <= lane_byte(hold_r[IQ_WIDTH-1:0], 1'b0);
                  end else begin
                     i_data_r <= {SERDES_RATIO{1'b0}};
                     q_data_r <= {SERDES_RATIO{1'b0}};
                     lo_i_r   <= {SERDES_RATIO{1'b0}};
                     lo_q_r   <= {SERDES_RATIO{1'b0}};
                  end
                  if (underflow_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                     cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                  end
               end else begin
                  i_data_r <= lo_i_r;
                  q_data_r <= lo_q_r;
                  strobe_r <= lane_byte(STROBE_PATTERN, 1'b0);
               end
            end
            default: begin
               i_data_r <= {SERDES_RATIO{1'b0}};
               q_data_r <= {SERDES_RATIO{1'b0}};
               strobe_r <= {SERDES_RATIO{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adrv9001_tx_unpack.sv
// Self-checking bench for adrv9001_tx_unpack: queue-based word-slot reference model,
// directed checks of the documented byte values and a receive-side loopback.
module tb_adrv9001_tx_unpack;

   localparam int          CW  = 4;
   localparam logic [15:0] PAT = 16'h8000;

   logic          clk    = 1'b0;
   logic          rstn   = 1'b1;
   logic [31:0]   tdata  = 32'h0;
   logic          tvalid = 1'b0;
   logic          tx_en  = 1'b0;
   logic          tready;
   logic [7:0]    i_data, q_data, strobe;
   logic          active;
   logic [CW-1:0] ucnt;

   always #5 clk = ~clk;

   adrv9001_tx_unpack #(.STROBE_PATTERN(PAT), .CNT_WIDTH(CW)) dut (
      .s_axis_aclk   (clk),
      .s_axis_rstn   (rstn),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .tx_en         (tx_en),
      .i_data        (i_data),
      .q_data        (q_data),
      .strobe        (strobe),
      .active        (active),
      .underflow_cnt (ucnt)
   );

   typedef struct packed {
      logic [7:0] i;
      logic [7:0] q;
      logic [7:0] s;
   } lane_t;

   // reference model: a buffer of accepted samples and a queue of bytes still owed on the wire
   logic [31:0] m_buf[$];
   lane_t       m_outq[$];
   bit          m_run;
   int          m_cnt;
   bit          m_acc;
   logic [7:0]  exp_i, exp_q, exp_s;
   logic        exp_active, exp_tready;

   int n_tests = 0;
   int n_fail  = 0;

   // loopback recorder
   bit          rec_on = 1'b0;
   bit          have_up = 1'b0;
   logic [7:0]  up_i, up_q;
   logic [31:0] rec[$];
   logic [31:0] sent[$];
   logic [31:0] cur;
   logic [31:0] last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[7-k] = b[k];
      return r;
   endfunction

   function automatic lane_t word_byte(input logic [31:0] w, input bit upper);
      lane_t      res;
      logic [15:0] p;
      p = PAT;
      if (upper) begin
         res.i = rev8(w[31:24]); res.q = rev8(w[15:8]);  res.s = rev8(p[15:8]);
      end else begin
         res.i = rev8(w[23:16]); res.q = rev8(w[7:0]);   res.s = rev8(p[7:0]);
      end
      return res;
   endfunction

   // predicts the outputs after the coming clock edge from the inputs now driven
   task automatic model_step(input bit r, input bit v, input bit e, input logic [31:0] d);
      logic [31:0] w;
      lane_t       b;
      if (!r) begin
         m_buf.delete(); m_outq.delete();
         m_run = 1'b0; m_cnt = 0; m_acc = 1'b0;
         exp_i = 8'h0; exp_q = 8'h0; exp_s = 8'h0; exp_active = 1'b0; exp_tready = 1'b0;
         return;
      end
      m_acc = v && exp_tready;
      if (m_run) begin
         if (m_outq.size() == 0) begin
            if (m_buf.size() != 0) begin
               w = m_buf.pop_front();
            end else begin
               w = 32'h0;
               if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_outq.push_back(word_byte(w, 1'b1));
            m_outq.push_back(word_byte(w, 1'b0));
         end
         b = m_outq.pop_front();
         exp_i = b.i; exp_q = b.q; exp_s = b.s;
         if (m_outq.size() == 0 && !e) m_run = 1'b0;
      end else begin
         exp_i = 8'h0; exp_q = 8'h0; exp_s = 8'h0;
         if (e && m_buf.size() != 0) m_run = 1'b1;
      end
      if (m_acc) m_buf.push_back(d);
      exp_tready = (m_buf.size() == 0) || (m_run && m_outq.size() == 0);
      exp_active = m_run;
   endtask

   // one clock: drive at the falling edge, let the rising edge happen, check at the next falling edge
   task automatic cycle(input bit r, input bit v, input bit e);
      rstn = r; tvalid = v; tx_en = e; tdata = v ? cur : $urandom;
      model_step(r, v, e, tdata);
      @(negedge clk);
      check("i_data", i_data, exp_i);
      check("q_data", q_data, exp_q);
      check("strobe", strobe, exp_s);
      check("active", active, exp_active);
      check("tready", tready, exp_tready);
      check("ucnt", ucnt, m_cnt);
      if (rec_on) begin
         if (strobe === 8'h01) begin
            up_i = i_data; up_q = q_data; have_up = 1'b1;
         end else if (have_up && strobe === 8'h00) begin
            rec.push_back({rev8(up_i), rev8(i_data), rev8(up_q), rev8(q_data)});
            have_up = 1'b0;
         end
      end
      if (m_acc) begin
         last_acc = cur;
         cur = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          found;
      bit          pulsed;
      logic [31:0] held;
      cur = $urandom;
      #1 rstn = 1'b0;
      @(negedge clk);

      // 1: reset with tvalid high
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
      check("rst_tready", tready, 32'h0);
      check("rst_cnt", ucnt, 32'h0);

      // 2: single sample then an underflow word
      cycle(1'b1, 1'b0, 1'b0);
      cur = 32'h1234_ABCD;
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      check("t2_idle_i", i_data, 32'h0);
      cycle(1'b1, 1'b0, 1'b1);
      check("t2_i_hi", i_data, 32'h48);
      check("t2_q_hi", q_data, 32'hD5);
      check("t2_s_hi", strobe, 32'h01);
      cycle(1'b1, 1'b0, 1'b1);
      check("t2_i_lo", i_data, 32'h2C);
      check("t2_q_lo", q_data, 32'hB3);
      check("t2_s_lo", strobe, 32'h00);
      cycle(1'b1, 1'b0, 1'b1);
      check("t2_uf_i", i_data, 32'h0);
      check("t2_uf_s", strobe, 32'h01);
      check("t2_uf_cnt", ucnt, 32'h1);
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0);

      // 3: 100-sample continuous stream with loopback recovery
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      rec_on = 1'b1;
      for (int k = 0; k < 1000 && sent.size() < 100; k++) begin
         cycle(1'b1, 1'b1, 1'b1);
         if (m_acc) sent.push_back(last_acc);
      end
      check("t3_sent", sent.size(), 32'd100);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1);
      check("t3_no_uf", ucnt, 32'h0);
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0);
      rec_on = 1'b0;
      check("t3_rec_n", (rec.size() >= 100), 32'h1);
      for (int k = 0; k < 100 && k < rec.size() && k < sent.size(); k++)
         check("t3_loopback", rec[k], sent[k]);

      // 4: tx_en dropped in a phase-0 cycle, held sample goes first on re-enable
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (k > 4 && m_run && m_outq.size() == 0 && m_buf.size() != 0) found = 1'b1;
         else cycle(1'b1, 1'b1, 1'b1);
      end
      check("t4_found", found, 32'h1);
      cycle(1'b1, 1'b1, 1'b0);
      check("t4_hi_s", strobe, 32'h01);
      cycle(1'b1, 1'b1, 1'b0);
      check("t4_lo_s", strobe, 32'h00);
      check("t4_exit", active, 32'h0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
      check("t4_idle_i", i_data, 32'h0);
      check("t4_idle_act", active, 32'h0);
      held = (m_buf.size() != 0) ? m_buf[0] : 32'h0;
      check("t4_held", m_buf.size(), 32'h1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      check("t4_first_i", i_data, rev8(held[31:24]));
      check("t4_first_q", q_data, rev8(held[15:8]));
      for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0);

      // 5: counter saturation with CNT_WIDTH=4
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 84; k++) cycle(1'b1, 1'b0, 1'b1);
      check("t5_sat", ucnt, 32'hF);
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0);

      // 6: random gaps with a reset pulse mid-word
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      pulsed = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!pulsed && k >= 150 && m_run && m_outq.size() == 1) begin
            cycle(1'b0, 1'b1, 1'b1);
            pulsed = 1'b1;
            check("t6_rst_i", i_data, 32'h0);
            check("t6_rst_s", strobe, 32'h0);
            check("t6_rst_act", active, 32'h0);
            check("t6_rst_rdy", tready, 32'h0);
         end else begin
            cycle(1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0));
         end
      end
      check("t6_pulsed", pulsed, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
